// File: rtl/hazard_ctrl_param.sv
// Hazard control for a 5-stage RV32I pipeline: nearest-first forwarding over FWD_DEPTH
// write-back sources, multi-cycle load-use stalls, redirect flushes and saturating statistics.
module hazard_ctrl_param #(
   parameter int REG_AW    = 5,
   parameter int FWD_DEPTH = 3,
   parameter int LOAD_LAT  = 1,
   parameter int CNT_W     = 16,
   parameter int SEL_W     = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          id_valid,
   input  logic [REG_AW-1:0]             id_rs1,
   input  logic [REG_AW-1:0]             id_rs2,
   input  logic                          id_use_rs1,
   input  logic                          id_use_rs2,
   input  logic                          ex_valid,
   input  logic [REG_AW-1:0]             ex_rs1,
   input  logic [REG_AW-1:0]             ex_rs2,
   input  logic [REG_AW-1:0]             ex_rd,
   input  logic                          ex_regwrite,
   input  logic                          ex_is_load,
   input  logic                          ex_redirect,
   input  logic [FWD_DEPTH*REG_AW-1:0]   fwd_rd,
   input  logic [FWD_DEPTH-1:0]          fwd_we,
   input  logic                          clr_stats,
   output logic                          stall_f,
   output logic                          stall_d,
   output logic                          flush_d,
   output logic                          flush_e,
   output logic [SEL_W-1:0]              fwd_sel_a,
   output logic [SEL_W-1:0]              fwd_sel_b,
   output logic                          busy,
   output logic [CNT_W-1:0]              stall_cnt,
   output logic [CNT_W-1:0]              flush_cnt
);

   typedef enum logic {IDLE, LSTALL} state_t;

   localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       hz;
   logic       stall;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Scan from the farthest source down so the nearest match is the one that sticks.
   function automatic logic [SEL_W-1:0] fwd_pick(
      input logic [REG_AW-1:0]           rs,
      input logic [FWD_DEPTH*REG_AW-1:0] rd,
      input logic [FWD_DEPTH-1:0]        we
   );
      logic [SEL_W-1:0]  sel;
      logic [REG_AW-1:0] r;
      sel = '0;
      for (int k = FWD_DEPTH; k >= 1; k--) begin
         r = rd[(k-1)*REG_AW +: REG_AW];
         if (we[k-1] && (r != '0) && (r == rs)) sel = SEL_W'(k);
      end
      return sel;
   endfunction

   assign hz = id_valid & ex_valid & ex_is_load & ex_regwrite & (ex_rd != '0) &
               ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

   // A redirect kills any pending or new stall in the same cycle.
   assign stall     = rst & ~ex_redirect & ((state == LSTALL) | hz);
   assign stall_f   = stall;
   assign stall_d   = stall;
   assign flush_d   = ~rst | ex_redirect;
   assign flush_e   = ~rst | ex_redirect | stall;
   assign busy      = rst & (state == LSTALL);
   assign fwd_sel_a = rst ? fwd_pick(ex_rs1, fwd_rd, fwd_we) : '0;
   assign fwd_sel_b = rst ? fwd_pick(ex_rs2, fwd_rd, fwd_we) : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (ex_redirect) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (state == IDLE) begin
            if (hz && (LOAD_LAT > 1)) begin
               state <= LSTALL;
               cnt   <= LAT_M1;
            end
         end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= IDLE;
         end

         if (clr_stats) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
         end else begin
            if (stall)       stall_cnt <= sat_inc(stall_cnt);
            if (ex_redirect) flush_cnt <= sat_inc(flush_cnt);
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Directed bench for hazard_ctrl_param: two instances (LOAD_LAT=1/CNT_W=4 and LOAD_LAT=3/CNT_W=16)
// share stimulus; expected values go through a scoreboard queue.
module tb_hazard_ctrl_param;

   localparam int AW = 5;
   localparam int FD = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, id_valid, id_use_rs1, id_use_rs2, ex_valid, ex_regwrite, ex_is_load, ex_redirect, clr_stats;
   logic [AW-1:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
   logic [FD*AW-1:0] fwd_rd;
   logic [FD-1:0]    fwd_we;

   logic a_stall_f, a_stall_d, a_flush_d, a_flush_e, a_busy;
   logic b_stall_f, b_stall_d, b_flush_d, b_flush_e, b_busy;
   logic [1:0]  a_sel_a, a_sel_b, b_sel_a, b_sel_b;
   logic [3:0]  a_stall_cnt, a_flush_cnt;
   logic [15:0] b_stall_cnt, b_flush_cnt;
   logic [4:0]  ctl_a, ctl_b;

   assign ctl_a = {a_stall_f, a_stall_d, a_flush_d, a_flush_e, a_busy};
   assign ctl_b = {b_stall_f, b_stall_d, b_flush_d, b_flush_e, b_busy};

   localparam logic [4:0] C_NONE = 5'b00000;
   localparam logic [4:0] C_HZ   = 5'b11010;
   localparam logic [4:0] C_LST  = 5'b11011;
   localparam logic [4:0] C_FLSH = 5'b00110;
   localparam logic [4:0] C_RLST = 5'b00111;

   hazard_ctrl_param #(.REG_AW(AW), .FWD_DEPTH(FD), .LOAD_LAT(1), .CNT_W(4), .SEL_W(2)) dut_a (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid), .ex_rs1(ex_rs1),
      .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
      .ex_redirect(ex_redirect), .fwd_rd(fwd_rd), .fwd_we(fwd_we), .clr_stats(clr_stats),
      .stall_f(a_stall_f), .stall_d(a_stall_d), .flush_d(a_flush_d), .flush_e(a_flush_e),
      .fwd_sel_a(a_sel_a), .fwd_sel_b(a_sel_b), .busy(a_busy),
      .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

   hazard_ctrl_param #(.REG_AW(AW), .FWD_DEPTH(FD), .LOAD_LAT(3), .CNT_W(16), .SEL_W(2)) dut_b (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid), .ex_rs1(ex_rs1),
      .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
      .ex_redirect(ex_redirect), .fwd_rd(fwd_rd), .fwd_we(fwd_we), .clr_stats(clr_stats),
      .stall_f(b_stall_f), .stall_d(b_stall_d), .flush_d(b_flush_d), .flush_e(b_flush_e),
      .fwd_sel_a(b_sel_a), .fwd_sel_b(b_sel_b), .busy(b_busy),
      .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s observed %0h but scoreboard is empty", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, e);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_valid = 1'b0; ex_regwrite = 1'b1; ex_is_load = 1'b1; ex_redirect = 1'b0; clr_stats = 1'b0;
      id_rs1 = '0; id_rs2 = '0; ex_rs1 = 5'd5; ex_rs2 = '0; ex_rd = '0;
      fwd_we = 3'b111; fwd_rd = {5'd5, 5'd5, 5'd5};

      // reset forcing: forward match present but select held at 0
      step(); step();
      push(C_FLSH); push(C_FLSH); push(0); push(0); push(0);
      #1;
      chk("rst_ctl_a", ctl_a); chk("rst_ctl_b", ctl_b); chk("rst_sel_a", a_sel_a);
      chk("rst_stall_cnt_a", a_stall_cnt); chk("rst_flush_cnt_b", b_flush_cnt);

      // forwarding priority
      step(); rst = 1'b1;
      push(1); push(C_NONE); #1; chk("fwd_all_we", a_sel_a); chk("fwd_ctl", ctl_a);
      step(); fwd_we = 3'b110;
      push(2); #1; chk("fwd_we110", a_sel_a);
      step(); fwd_we = 3'b100; ex_rs2 = 5'd5;
      push(3); push(3); #1; chk("fwd_we100_a", a_sel_a); chk("fwd_we100_b", b_sel_b);
      step(); fwd_we = 3'b111; fwd_rd = {5'd9, 5'd9, 5'd4}; ex_rs1 = 5'd4; ex_rs2 = 5'd9;
      push(2); push(1); #1; chk("fwd_mixed_b", a_sel_b); chk("fwd_mixed_a", a_sel_a);
      step(); fwd_rd = '0; ex_rs1 = '0; ex_rs2 = '0;
      push(0); push(0); #1; chk("fwd_x0_a", a_sel_a); chk("fwd_x0_b", b_sel_b);

      // load-use via rs2
      step(); ex_valid = 1'b1; ex_rd = 5'd7; id_valid = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
      push(C_HZ); push(C_HZ); #1; chk("lu_c1_a", ctl_a); chk("lu_c1_b", ctl_b);
      step(); ex_valid = 1'b0;
      push(C_NONE); push(C_LST); push(1); #1;
      chk("lu_c2_a", ctl_a); chk("lu_c2_b", ctl_b); chk("lu_stall_cnt_a", a_stall_cnt);
      step();
      push(C_NONE); push(C_LST); push(2); #1;
      chk("lu_c3_a", ctl_a); chk("lu_c3_b", ctl_b); chk("lu_stall_cnt_b2", b_stall_cnt);
      step();
      push(C_NONE); push(3); push(1); #1;
      chk("lu_end_b", ctl_b); chk("lu_stall_cnt_b3", b_stall_cnt); chk("lu_stall_cnt_a_end", a_stall_cnt);

      // no false hazard
      step(); ex_valid = 1'b1; ex_rd = '0; id_rs2 = '0;
      push(C_NONE); push(C_NONE); #1; chk("nf_rd0_a", ctl_a); chk("nf_rd0_b", ctl_b);
      step(); ex_rd = 5'd7; id_rs2 = 5'd7; id_valid = 1'b0;
      push(C_NONE); push(C_NONE); #1; chk("nf_idv_a", ctl_a); chk("nf_idv_b", ctl_b);
      step(); id_valid = 1'b1; id_use_rs2 = 1'b0; id_use_rs1 = 1'b0; id_rs1 = 5'd7;
      push(C_NONE); push(C_NONE); #1; chk("nf_use_a", ctl_a); chk("nf_use_b", ctl_b);
      step();
      push(1); push(3); push(C_NONE); #1;
      chk("nf_cnt_a", a_stall_cnt); chk("nf_cnt_b", b_stall_cnt); chk("nf_idle_b", ctl_b);

      // clear statistics
      step(); ex_valid = 1'b0; clr_stats = 1'b1;
      step(); clr_stats = 1'b0;
      push(0); push(0); #1; chk("clr_a", a_stall_cnt); chk("clr_b", b_stall_cnt);

      // redirect during LSTALL (hazard via rs1)
      step(); ex_valid = 1'b1; id_use_rs1 = 1'b1;
      push(C_HZ); push(C_HZ); #1; chk("rd_c1_a", ctl_a); chk("rd_c1_b", ctl_b);
      step(); ex_valid = 1'b0; ex_redirect = 1'b1;
      push(C_FLSH); push(C_RLST); #1; chk("rd_c2_a", ctl_a); chk("rd_c2_b", ctl_b);
      step(); ex_redirect = 1'b0;
      push(C_NONE); push(1); push(1); push(1); push(1); #1;
      chk("rd_idle_b", ctl_b); chk("rd_stall_cnt_b", b_stall_cnt); chk("rd_flush_cnt_b", b_flush_cnt);
      chk("rd_stall_cnt_a", a_stall_cnt); chk("rd_flush_cnt_a", a_flush_cnt);
      step();
      push(C_NONE); #1; chk("rd_stay_b", ctl_b);

      // redirect coinciding with a hazard in IDLE discards the hazard
      step(); ex_valid = 1'b1; ex_redirect = 1'b1;
      push(C_FLSH); push(C_FLSH); #1; chk("rh_a", ctl_a); chk("rh_b", ctl_b);
      step(); ex_valid = 1'b0; ex_redirect = 1'b0;
      push(C_NONE); push(1); push(2); #1;
      chk("rh_idle_b", ctl_b); chk("rh_stall_cnt_b", b_stall_cnt); chk("rh_flush_cnt_b", b_flush_cnt);

      // saturation on the 4-bit instance
      step(); clr_stats = 1'b1;
      step(); clr_stats = 1'b0; ex_valid = 1'b1;
      repeat (19) step();
      step(); clr_stats = 1'b1;
      push(15); push(0); #1; chk("sat_stall_cnt_a", a_stall_cnt); chk("sat_flush_cnt_a", a_flush_cnt);
      step(); clr_stats = 1'b0; ex_valid = 1'b0;
      push(0); push(0); #1; chk("clr_inc_a", a_stall_cnt); chk("clr_inc_b", b_stall_cnt);

      // reset in the middle of LSTALL
      step(); step(); step();
      push(C_NONE); #1; chk("pre_idle_b", ctl_b);
      step(); ex_valid = 1'b1;
      push(C_HZ); #1; chk("mr_c1_b", ctl_b);
      step(); ex_valid = 1'b0;
      push(C_LST); #1; chk("mr_c2_b", ctl_b);
      step(); rst = 1'b0; ex_valid = 1'b1;
      push(C_FLSH); push(C_FLSH); #1; chk("mr_rst_b", ctl_b); chk("mr_rst_a", ctl_a);
      step(); rst = 1'b1; ex_valid = 1'b0;
      push(C_NONE); push(0); push(0); push(0); #1;
      chk("mr_idle_b", ctl_b); chk("mr_stall_cnt_b", b_stall_cnt);
      chk("mr_stall_cnt_a", a_stall_cnt); chk("mr_flush_cnt_b", b_flush_cnt);
      step();
      push(C_NONE); #1; chk("mr_stay_b", ctl_b);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_param.md
Name: hazard_ctrl_param

Overview:
- Parametrised successor to the current 5-stage RV32I forwarding logic.
- Generalises forwarding to FWD_DEPTH downstream write-back sources, picking the nearest producer first.
- Adds load-use stall sequencing with configurable load latency, branch/jump redirect flushing, and saturating stall/flush statistics counters.
- Sits beside the pipeline stages; drives the stall, flush and forward-select controls of the fetch, decode and execute stages.

Parameters:
- REG_AW, 5, register index width (register file has 2^REG_AW entries; index 0 is hardwired zero).
- FWD_DEPTH, 3, number of forwarding sources; source 1 is nearest to EX (M), then W, then the post-writeback stage.
- LOAD_LAT, 1, number of bubble cycles a load-use hazard requires (1..15).
- CNT_W, 16, width of the statistics counters.
- SEL_W, 2, forward-select width; must be at least clog2(FWD_DEPTH+1).

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, synchronous active-low reset.
- id_valid, input, 1, decode-stage instruction valid.
- id_rs1, input, REG_AW, decode source 1.
- id_rs2, input, REG_AW, decode source 2.
- id_use_rs1, input, 1, decode instruction reads rs1.
- id_use_rs2, input, 1, decode instruction reads rs2.
- ex_valid, input, 1, execute-stage instruction valid.
- ex_rs1, input, REG_AW, execute source 1.
- ex_rs2, input, REG_AW, execute source 2.
- ex_rd, input, REG_AW, execute destination.
- ex_regwrite, input, 1, execute instruction writes rd.
- ex_is_load, input, 1, execute instruction is a load.
- ex_redirect, input, 1, taken branch, JAL or JALR resolved in EX.
- fwd_rd, input, FWD_DEPTH*REG_AW, packed destinations; slice k-1 belongs to source k.
- fwd_we, input, FWD_DEPTH, write enable per source; bit k-1 belongs to source k.
- clr_stats, input, 1, synchronous clear of the statistics counters.
- stall_f, output, 1, hold PC.
- stall_d, output, 1, hold the IF/ID register.
- flush_d, output, 1, clear the IF/ID register.
- flush_e, output, 1, clear the ID/EX register (insert bubble).
- fwd_sel_a, output, SEL_W, EX operand A select: 0 = register file, k = source k.
- fwd_sel_b, output, SEL_W, EX operand B select, same encoding as fwd_sel_a.
- busy, output, 1, FSM is in LSTALL.
- stall_cnt, output, CNT_W, count of cycles with stall_d asserted.
- flush_cnt, output, CNT_W, count of accepted redirects.

Behaviour:

Reset
- While rst=0 at a clock edge: state <= IDLE, cnt <= 0, stall_cnt <= 0, flush_cnt <= 0.
- While rst=0, outputs are forced combinationally: flush_d=1, flush_e=1, stall_f=0, stall_d=0, fwd_sel_a=0, fwd_sel_b=0, busy=0.
- Reset asserted mid-stall aborts the stall; the FSM is IDLE on the first cycle after rst returns to 1.

Forwarding (combinational, zero latency)
- Source k matches operand A when fwd_we[k-1]=1, fwd_rd slice k-1 is nonzero, and it equals ex_rs1.
- fwd_sel_a = the lowest matching k; 0 if there is no match.
- fwd_sel_b: same rule using ex_rs2.
- Register 0 never forwards.

Load-use hazard
- hz = id_valid & ex_valid & ex_is_load & ex_regwrite & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).

FSM
- IDLE:
  - If ex_redirect: flush_d=1, flush_e=1, no stall; remain in IDLE.
  - Else if hz: stall_f=1, stall_d=1, flush_e=1. If LOAD_LAT>1, go to LSTALL with cnt <= LOAD_LAT-1; otherwise remain in IDLE.
  - Else: all controls 0.
- LSTALL:
  - Outputs: busy=1, stall_f=1, stall_d=1, flush_e=1.
  - cnt decrements each cycle; when cnt=1, the next state is IDLE.
  - Total stall cycles per hazard = LOAD_LAT, regardless of ex_valid during the stall.
- Redirect priority: ex_redirect in any state wins.
  - Output that cycle: flush_d=1, flush_e=1, stall_f=0, stall_d=0.
  - Next state is IDLE and cnt <= 0.
  - A hazard coinciding with a redirect is discarded.

Statistics
- stall_cnt increments on each cycle with stall_d=1.
- flush_cnt increments on each cycle with an accepted ex_redirect (rst=1).
- Both counters saturate at 2^CNT_W-1 and never wrap.
- If clr_stats=1 in the same cycle as an increment, clear wins; both counters read 0 next cycle.

Test Plan:
1. Forward priority: FWD_DEPTH=3; fwd_we=3'b111, all fwd_rd=5, ex_rs1=5 -> fwd_sel_a=1. Then fwd_we=3'b110 -> fwd_sel_a=2. Then ex_rs1=0 with all fwd_rd=0 -> fwd_sel_a=0.
2. Load-use, LOAD_LAT=1: EX load with rd=7, ID rs2=7, id_use_rs2=1 -> exactly 1 cycle with stall_f=stall_d=flush_e=1, busy stays 0; stall_cnt=1.
3. Load-use, LOAD_LAT=3: same stimulus -> 3 consecutive stall cycles, busy=1 in cycles 2-3, then IDLE; stall_cnt=3.
4. Redirect in LSTALL: LOAD_LAT=3, ex_redirect=1 in stall cycle 2 -> that cycle flush_d=flush_e=1, stall_f=stall_d=0; next cycle IDLE, busy=0; flush_cnt=1, stall_cnt=1.
5. No false hazard: load with rd=0, or id_valid=0, or id_use_rs1=0 with rs1 matching -> no stall, state remains IDLE.
6. Reset and saturation: CNT_W=4, hold the hazard for 20 cycles -> stall_cnt=15. Drive rst=0 mid-LSTALL -> flush_d=flush_e=1 and stall outputs 0 while rst=0; counters read 0 after reset. clr_stats coincident with an increment -> 0.
